display_mode_ctrl: RTL and testbench

Sequencer for the health monitor's 16-bit display-select mux: produces the `mode` select that chooses between the reaction-timer result (`mode`=0) and the pulse-rate value (`mode`=1). The user's button toggles the base view. A fresh reaction result pre-empts the display for a fixed hold time. Optionally, the view auto-alternates on a slow tick. The block sits between the debounced button and the two measurement blocks on one side, and the display mux select on the other.

---
 rtl/display_mode_ctrl.sv | 128 ++++++++++++
 tb/tb_display_mode_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/display_mode_ctrl.sv
// Display-select sequencer: user toggle, reaction-result pre-emption hold and
// optional auto-alternation (compile with AUTO_CYCLE_EN to enable auto-cycle).
module display_mode_ctrl #(
  parameter int DWELL_TICKS = 5,
  parameter int HOLD_TICKS  = 3,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  input  logic auto_sw,
  input  logic react_done,
  input  logic pulse_upd,
  output logic mode,
  output logic preempt,
  output logic switch_pulse
);

  typedef enum logic {VIEW, HOLD} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

  state_t           state, state_nxt;
  logic             base_sel, base_sel_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             pulse_seen;
  logic             btn_q;
  logic             btn_edge;
  logic             mode_nxt;

`ifdef AUTO_CYCLE_EN
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_nxt;
`else
  // Without auto-cycle, the switch and the pulse history have no consumer.
  logic unused_auto;
  assign unused_auto = auto_sw ^ pulse_seen;
`endif

  assign btn_edge = btn & ~btn_q;

  // NOTE: every variable assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    base_sel_nxt  = base_sel;
    hold_cnt_nxt  = hold_cnt;
`ifdef AUTO_CYCLE_EN
    dwell_cnt_nxt = dwell_cnt;
`endif
    case (state)
      VIEW: begin
        if (react_done) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
        end else if (btn_edge) begin
          base_sel_nxt  = ~base_sel;
`ifdef AUTO_CYCLE_EN
          dwell_cnt_nxt = '0;
        end else if (auto_sw && tick) begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt_nxt = '0;
            // Never auto-switch to the pulse view before any pulse value exists.
            base_sel_nxt  = base_sel ? 1'b0 : pulse_seen;
          end else begin
            dwell_cnt_nxt = dwell_cnt + CNT_W'(1);
          end
`endif
        end
      end
      HOLD: begin
        if (react_done) begin
          hold_cnt_nxt = '0;
        end else if (btn_edge) begin
          state_nxt     = VIEW;
          base_sel_nxt  = 1'b1;
`ifdef AUTO_CYCLE_EN
          dwell_cnt_nxt = '0;
`endif
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt     = VIEW;
            hold_cnt_nxt  = '0;
`ifdef AUTO_CYCLE_EN
            dwell_cnt_nxt = '0;
`endif
          end else begin
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = VIEW;
    endcase
    mode_nxt = (state_nxt == HOLD) ? 1'b0 : base_sel_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= VIEW;
      base_sel     <= 1'b0;
      hold_cnt     <= '0;
      pulse_seen   <= 1'b0;
      btn_q        <= 1'b1;  // a button held through reset yields no edge
      mode         <= 1'b0;
      preempt      <= 1'b0;
      switch_pulse <= 1'b0;
`ifdef AUTO_CYCLE_EN
      dwell_cnt    <= '0;
`endif
    end else begin
      state        <= state_nxt;
      base_sel     <= base_sel_nxt;
      hold_cnt     <= hold_cnt_nxt;
      pulse_seen   <= pulse_seen | pulse_upd;
      btn_q        <= btn;
      mode         <= mode_nxt;
      preempt      <= (state_nxt == HOLD);
      switch_pulse <= (mode_nxt != mode);
`ifdef AUTO_CYCLE_EN
      dwell_cnt    <= dwell_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Scoreboard bench for display_mode_ctrl: directed scenarios then random
// traffic, each cycle checked against a countdown-style reference model.
module tb_display_mode_ctrl;

  localparam int DWELL = 5;
  localparam int HOLDT = 3;
`ifdef AUTO_CYCLE_EN
  localparam bit AUTO_BUILD = 1'b1;
`else
  localparam bit AUTO_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, btn = 1'b1, auto_sw = 1'b0, react_done = 1'b0, pulse_upd = 1'b0;
  logic mode, preempt, switch_pulse;

  always #5 clk = ~clk;

  display_mode_ctrl #(.DWELL_TICKS(DWELL), .HOLD_TICKS(HOLDT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn), .auto_sw(auto_sw),
    .react_done(react_done), .pulse_upd(pulse_upd),
    .mode(mode), .preempt(preempt), .switch_pulse(switch_pulse)
  );

  typedef struct packed {
    logic mode;
    logic preempt;
    logic sw;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
    end
  endtask

  // Reference model: the hold is a number of ticks still to wait, the dwell is
  // the number of ticks spent in the current view.
  bit m_in_hold = 0, m_view = 0, m_seen = 0, m_btn_prev = 1, m_mode = 0;
  int m_hold_left = 0, m_dwell = 0;

  function automatic exp_t model(input bit r, t, b, a, rd, pu);
    exp_t e;
    bit edge_, new_mode;
    if (!r) begin
      m_in_hold = 0; m_view = 0; m_seen = 0; m_btn_prev = 1; m_mode = 0;
      m_hold_left = 0; m_dwell = 0;
      e = '0;
      return e;
    end
    edge_ = b && !m_btn_prev;
    if (rd) begin
      m_in_hold = 1;
      m_hold_left = HOLDT;
    end else if (m_in_hold) begin
      if (edge_) begin
        m_in_hold = 0; m_view = 1; m_dwell = 0;
      end else if (t) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_in_hold = 0; m_dwell = 0;
        end
      end
    end else begin
      if (edge_) begin
        m_view = !m_view; m_dwell = 0;
      end else if (AUTO_BUILD && a && t) begin
        m_dwell++;
        if (m_dwell == DWELL) begin
          m_dwell = 0;
          if (m_view) m_view = 0;
          else if (m_seen) m_view = 1;
        end
      end
    end
    if (pu) m_seen = 1;
    m_btn_prev = b;
    new_mode = m_in_hold ? 1'b0 : m_view;
    e.mode = new_mode;
    e.preempt = m_in_hold;
    e.sw = (new_mode != m_mode);
    m_mode = new_mode;
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, push the expectation
  // for the following rising edge.
  task automatic step(input bit r, t, b, a, rd, pu);
    @(negedge clk);
    rst_n = r; tick = t; btn = b; auto_sw = a; react_done = rd; pulse_upd = pu;
    sb.push_back(model(r, t, b, a, rd, pu));
  endtask

  // Monitor: pops one expectation per rising edge that has one pending.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("mode", mode, e.mode);
      check("preempt", preempt, e.preempt);
      check("switch_pulse", switch_pulse, e.sw);
    end
  end

  bit b_l = 1, a_l = 0;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, b_l, a_l, 0, 0);
  endtask

  task automatic do_tick();
    step(1, 1, b_l, a_l, 0, 0);
    idle(1);
  endtask

  task automatic press();
    b_l = 0; idle(1);
    b_l = 1; idle(2);
  endtask

  initial begin
    // Button held through reset, released, then pressed.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    press();
    // Reaction pre-empts the pulse view, exits after three ticks.
    step(1, 0, b_l, a_l, 1, 0);
    idle(2);
    for (int i = 0; i < HOLDT; i++) do_tick();
    idle(2);
    // Hold restart on the 2nd tick, then three more ticks to exit.
    step(1, 0, b_l, a_l, 1, 0);
    do_tick();
    step(1, 1, b_l, a_l, 1, 0);
    for (int i = 0; i < HOLDT; i++) do_tick();
    // Button edge during HOLD exits to the pulse view.
    step(1, 0, b_l, a_l, 1, 0);
    do_tick();
    press();
    // react_done, button edge and tick in the same cycle with mode=1.
    b_l = 0; idle(1);
    b_l = 1;
    step(1, 1, b_l, a_l, 1, 0);
    idle(1);
    for (int i = 0; i < HOLDT; i++) do_tick();
    // Reset mid-HOLD with two ticks already counted.
    step(1, 0, b_l, a_l, 1, 0);
    do_tick();
    do_tick();
    step(0, 0, b_l, a_l, 0, 0);
    do_tick();
    idle(2);
`ifdef AUTO_CYCLE_EN
    // Auto-cycle: suppressed until a pulse value has been seen.
    step(0, 0, b_l, 0, 0, 0);
    a_l = 1;
    idle(1);
    for (int i = 0; i < 2 * DWELL; i++) do_tick();
    step(1, 0, b_l, a_l, 0, 1);
    for (int i = 0; i < 2 * DWELL; i++) do_tick();
`endif
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, t, rd, pu;
      r  = ($urandom_range(0, 199) != 0);
      t  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 24) == 0);
      pu = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) b_l = !b_l;
      if ($urandom_range(0, 49) == 0) a_l = !a_l;
      step(r, t, b_l, a_l, rd, pu);
    end
    idle(1);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
